// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment reader: the active-low glyph
// patterns, the all-off blank pattern and the handshake FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {TRACK = 1'b0, OUT = 1'b1} state_t;

endpackage

// File: rtl/seg7_encode.sv
// Combinational inverse of the hex-to-segment decoder.
// SEG7_READER_BLANK_EN: all-off pattern decodes as a legal blank.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       err
`ifdef SEG7_READER_BLANK_EN
  ,
  output logic       blank
`endif
);

  // Map glyph to nibble; anything unrecognised flags err with nibble 0
  always_comb begin
    nibble = 4'h0;
    err    = 1'b0;
`ifdef SEG7_READER_BLANK_EN
    blank  = 1'b0;
`endif
    case (seg_n)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
`ifdef SEG7_READER_BLANK_EN
      SEG_BLANK: blank = 1'b1;
`endif
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Stability-filtered 7-segment reader with valid/ready output.
// One nibble is emitted per distinct qualified pattern; a distinct
// pattern qualifying while a result is still held sets sticky overrun.
// SEG7_READER_BLANK_EN: adds out_blank and treats 7'h7F as legal blank.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_n,
  input  logic       out_ready,
  input  logic       clr_overrun,
  output logic       out_valid,
  output logic [3:0] out_nibble,
  output logic       out_err,
`ifdef SEG7_READER_BLANK_EN
  output logic       out_blank,
`endif
  output logic       overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
`ifdef SEG7_READER_BLANK_EN
  localparam logic [6:0] LAST_PAT_RST = 7'h7F;
`else
  localparam logic [6:0] LAST_PAT_RST = 7'h7E;
`endif

  logic [6:0]       seg_q, seg_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [6:0]       last_pat_q, last_pat_d;
  logic             first_q, first_d;
  state_t           state_q, state_d;
  logic [3:0]       nib_q, nib_d;
  logic             err_q, err_d;
  logic             overrun_q, overrun_d;
  logic             qualified;
  logic [3:0]       enc_nib;
  logic             enc_err;
`ifdef SEG7_READER_BLANK_EN
  logic             blank_q, blank_d;
  logic             enc_blank;
`endif

  seg7_encode u_enc (
    .seg_n  (seg_q),
    .nibble (enc_nib),
`ifdef SEG7_READER_BLANK_EN
    .blank  (enc_blank),
`endif
    .err    (enc_err)
  );

  // Stability filter: count consecutive cycles the input matched the sample
  always_comb begin
    seg_d = seg_n;
    if (seg_n != seg_q)          stab_cnt_d = '0;
    else if (stab_cnt_q != CNT_MAX) stab_cnt_d = stab_cnt_q + CNT_W'(1);
    else                         stab_cnt_d = stab_cnt_q;
    // first bypasses the marker so a steady 7'h7E is still emitted once
    qualified = (stab_cnt_q == CNT_MAX) && (first_q || (seg_q != last_pat_q));
  end

  // Handshake FSM: capture on qualify, hold until consumer takes it
  always_comb begin
    state_d    = state_q;
    last_pat_d = last_pat_q;
    first_d    = first_q;
    nib_d      = nib_q;
    err_d      = err_q;
`ifdef SEG7_READER_BLANK_EN
    blank_d    = blank_q;
`endif
    overrun_d  = overrun_q & ~clr_overrun;
    case (state_q)
      TRACK: if (qualified) begin
        nib_d      = enc_nib;
        err_d      = enc_err;
`ifdef SEG7_READER_BLANK_EN
        blank_d    = enc_blank;
`endif
        last_pat_d = seg_q;
        first_d    = 1'b0;
        state_d    = OUT;
      end
      OUT: begin
        // dropped pattern stays un-latched so it re-qualifies after OUT
        if (qualified) overrun_d = 1'b1;
        if (out_ready) state_d = TRACK;
      end
      default: state_d = TRACK;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q      <= SEG_BLANK;
      stab_cnt_q <= '0;
      last_pat_q <= LAST_PAT_RST;
      first_q    <= 1'b1;
      state_q    <= TRACK;
      nib_q      <= 4'h0;
      err_q      <= 1'b0;
`ifdef SEG7_READER_BLANK_EN
      blank_q    <= 1'b0;
`endif
      overrun_q  <= 1'b0;
    end else begin
      seg_q      <= seg_d;
      stab_cnt_q <= stab_cnt_d;
      last_pat_q <= last_pat_d;
      first_q    <= first_d;
      state_q    <= state_d;
      nib_q      <= nib_d;
      err_q      <= err_d;
`ifdef SEG7_READER_BLANK_EN
      blank_q    <= blank_d;
`endif
      overrun_q  <= overrun_d;
    end
  end

  assign out_valid  = (state_q == OUT);
  assign out_nibble = nib_q;
  assign out_err    = err_q;
`ifdef SEG7_READER_BLANK_EN
  assign out_blank  = blank_q;
`endif
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader (STABLE_CYCLES=4).
module tb_seg7_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_n;
  logic       out_ready;
  logic       clr_overrun;
  logic       out_valid;
  logic [3:0] out_nibble;
  logic       out_err;
  logic       overrun;
`ifdef SEG7_READER_BLANK_EN
  logic       out_blank;
`endif

  typedef struct {
    logic [3:0] nib;
    logic       err;
    logic       blank;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_xfer = 0;

  always #5 clk = ~clk;

  seg7_reader #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .out_ready   (out_ready),
    .clr_overrun (clr_overrun),
    .out_valid   (out_valid),
    .out_nibble  (out_nibble),
    .out_err     (out_err),
`ifdef SEG7_READER_BLANK_EN
    .out_blank   (out_blank),
`endif
    .overrun     (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic push(input logic [3:0] nib, input logic err, input logic blank);
    exp_t e;
    e.nib = nib; e.err = err; e.blank = blank;
    sb.push_back(e);
  endtask

  // hold pat on seg_n for exactly 'cycles' rising edges
  task automatic drive(input logic [6:0] pat, input int cycles);
    @(negedge clk);
    seg_n = pat;
    repeat (cycles) @(posedge clk);
  endtask

  // check out_valid after each of 7 edges; pulse expected only after edge 6
  task automatic latency_check(input string tag);
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      chk(tag, 32'(out_valid), 32'(e == 6));
    end
  endtask

  // Monitor: transfer happens on the next rising edge when valid & ready
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n && out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("nibble", 32'(out_nibble), 32'(e.nib));
        chk("err",    32'(out_err),    32'(e.err));
`ifdef SEG7_READER_BLANK_EN
        chk("blank",  32'(out_blank),  32'(e.blank));
`endif
      end
      n_xfer++;
    end
  end

  logic [6:0] glyph [16];
  int         x0;
  bit         seen;

  initial begin
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst_n = 1'b0; seg_n = 7'h7F; out_ready = 1'b1; clr_overrun = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",   32'(out_valid),  32'd0);
    chk("rst_nibble",  32'(out_nibble), 32'd0);
    chk("rst_err",     32'(out_err),    32'd0);
    chk("rst_overrun", 32'(overrun),    32'd0);
`ifdef SEG7_READER_BLANK_EN
    chk("rst_blank",   32'(out_blank),  32'd0);
`endif

    // first pattern: exact latency, single pulse
    @(negedge clk);
    rst_n = 1'b1; seg_n = 7'h30;
    push(4'h3, 1'b0, 1'b0);
    latency_check("t1_vld");
    repeat (10) @(posedge clk);
    chk("t1_one_pulse", 32'(n_xfer), 32'd1);

    // sweep of all legal glyphs
    x0 = n_xfer;
    for (int i = 0; i < 16; i++) begin
      push(4'(i), 1'b0, 1'b0);
      drive(glyph[i], 10);
    end
    chk("sweep_cnt", 32'(n_xfer - x0), 32'd16);

    // blank and illegal patterns
`ifdef SEG7_READER_BLANK_EN
    push(4'h0, 1'b0, 1'b1);
`else
    push(4'h0, 1'b1, 1'b0);
`endif
    drive(7'h7F, 10);
    push(4'h0, 1'b1, 1'b0);
    drive(7'h55, 10);

    // short burst and single-cycle glitch must not emit
    x0 = n_xfer;
    drive(7'h24, 3);
    drive(7'h40, 1);
    push(4'h2, 1'b0, 1'b0);
    drive(7'h24, 10);
    chk("glitch_cnt", 32'(n_xfer - x0), 32'd1);

    // stall: second pattern dropped, overrun sticky, re-presented later
    @(negedge clk);
    out_ready = 1'b0;
    x0 = n_xfer;
    push(4'h1, 1'b0, 1'b0);
    push(4'h4, 1'b0, 1'b0);
    drive(7'h79, 8);
    drive(7'h19, 8);
    #1;
    chk("stall_valid",   32'(out_valid),  32'd1);
    chk("stall_nibble",  32'(out_nibble), 32'd1);
    chk("stall_overrun", 32'(overrun),    32'd1);
    chk("stall_noxfer",  32'(n_xfer - x0), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("stall_xfer",    32'(n_xfer - x0), 32'd2);
    chk("ovr_sticky",    32'(overrun),    32'd1);
    @(negedge clk);
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    chk("ovr_clear",     32'(overrun),    32'd0);
    @(negedge clk);
    clr_overrun = 1'b0;

    // async reset while a result is pending
    out_ready = 1'b0;
    seg_n = 7'h10;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      seen = out_valid;
    end
    chk("t7_vld_seen", 32'(seen), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t7_async_drop", 32'(out_valid), 32'd0);
    chk("t7_rst_nib",    32'(out_nibble), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    push(4'h9, 1'b0, 1'b0);
    latency_check("t7_vld");

    repeat (4) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
